ahb_axi_master_bridge: RTL and testbench
========================================

// Module: ahb_axi_master_bridge
// PURPOSE
//  In-house AHB-lite slave to AXI4 master bridge: the reverse of the AXI->AHB-lite slave bridge.
//  Lets AHB-lite bus masters (e.g. the USB controller DMA port) reach the AXI interconnect.
//  Replaces the vendor bridge for ASIC builds. 32-bit data.
//  Every AHB beat becomes exactly one single-beat AXI transaction; at most one is outstanding.
// PARAMETERS
//  AXI_ID_WIDTH  4  width of mst.aw_id/ar_id
//  AXI_ID        0  constant ID driven on aw_id/ar_id
// PORTS
//  aclk          in   1   bus clock; the only clock
//  aresetn       in   1   reset, asynchronous, active-low
//  s_hsel        in   1   slave select
//  s_haddr       in   32  address (address phase)
//  s_htrans      in   2   IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  s_hsize       in   3   0=byte 1=half 2=word
//  s_hburst      in   3   ignored; bursts are split into single beats
//  s_hprot       in   4   protection, mapped onto AXI cache/prot
//  s_hwrite      in   1   1=write
//  s_hwdata      in   32  write data (data phase)
//  s_hready_in   in   1   bus-level HREADY
//  s_hrdata      out  32  read data
//  s_hready_out  out  1   transfer done
//  s_hresp       out  1   1=ERROR
//  mst           AXI_BUS.Master  AXI4 master; 32-bit address, 32-bit data
// BEHAVIOUR
//  Reset values: s_hready_out=1, s_hresp=0, s_hrdata=0, all AXI valid/ready signals=0, FSM=IDLE.
//  Address phase is accepted when s_hsel & s_htrans[1] & s_hready_in. In that cycle the bridge
//    registers haddr, hsize, hwrite and hprot.
//  IDLE or BUSY transfers, or hsel=0: the bridge returns a zero-wait OKAY and issues nothing on AXI.
//  hsize>2: the bridge issues nothing on AXI and goes straight to ERR1.
//  FSM states: IDLE, WDATA, WADDR, WRESP, RADDR, RDATA, DONE, ERR1, ERR2.
//  Write path:
//    IDLE -> WDATA on accept. WDATA: hready_out=0, latch s_hwdata.
//    WADDR: aw_valid and w_valid rise together. Each drops independently on its own handshake.
//    Leave WADDR once both handshakes are done -> WRESP with b_ready=1.
//  Read path:
//    IDLE -> RADDR on accept. RADDR: ar_valid=1 until ar_ready.
//    RDATA: r_ready=1. On the r handshake, latch r_data into s_hrdata.
//  Response, b or r handshake:
//    resp==OKAY or EXOKAY -> DONE. DONE: hready_out=1, hresp=0, then IDLE.
//    SLVERR or DECERR -> ERR1. ERR1: hready_out=0, hresp=1. ERR2: hready_out=1, hresp=1, then IDLE.
//  A new address phase may be accepted in DONE or ERR2 (the hready_out=1 cycle). Back-to-back
//    transfers therefore have no idle cycle between them.
//  hready_out is 0 in every state except IDLE, DONE and ERR2.
//  AXI fields:
//    len=0, burst=INCR(01), id=AXI_ID, size=hsize, lock=0, qos=0, region=0.
//    addr=haddr unmodified.
//    prot={~hprot[0], 1'b0, hprot[1]}.
//    cache={2'b00, hprot[3], hprot[2]}.
//  w_strb from hsize and haddr[1:0]:
//    byte -> 4'b0001<<a[1:0].
//    half -> 4'b0011<<{a[1],1'b0}.
//    word -> 4'b1111.
//    w_last=1.
//  s_hwdata and r_data pass through unshifted: byte lanes follow the AHB address lanes.
//  Minimum latency, zero-wait AXI slave: write = accept + 4 cycles to hready_out=1;
//    read = accept + 3 cycles.
//  AXI ready signals arriving before valid have no effect. Valid signals never drop before
//    their handshake.
//  Reset mid-transfer: asynchronous return to reset values. An AXI transaction in flight is
//    abandoned; the system resets the interconnect at the same time.
// TESTING
//  1. Word write 0x1000_0004=0xDEADBEEF, zero-wait slave:
//     one AW+W with strb=1111, len=0; hready_out=1 exactly 4 cycles after accept; hresp=0.
//  2. Byte write at 0x...03, hwdata=0xAB000000:
//     w_strb=1000, aw_size=0; half write at 0x...02 -> w_strb=1100.
//  3. Word read, slave returns r_data=0x12345678 after a 5-cycle rvalid delay:
//     hrdata=0x12345678 in the DONE cycle; hready_out stays low throughout the wait.
//  4. Write with bresp=SLVERR:
//     ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); the next NONSEQ is accepted in ERR2.
//  5. aw_ready stalls 3 cycles while w_ready is immediate:
//     w_valid drops after 1 cycle, aw_valid holds; exactly one AW and one W are seen.
//  6. 4-beat INCR4 read:
//     four separate AR transactions with addresses +4 apart; aresetn low in RDATA -> all
//     outputs at reset values on the same edge.

Source files
------------

// File: rtl/ahb_axi_master_bridge_if.sv
// AXI4 bus bundle (32-bit address, 32-bit data) shared by the AHB-to-AXI bridge and its AXI peers.
// The Master modport is the issuing side; Slave is the responding side.
interface AXI_BUS #(
    parameter int AXI_ID_WIDTH = 4
) ();
    logic [AXI_ID_WIDTH-1:0] aw_id;
    logic [31:0]             aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [31:0]             w_data;
    logic [3:0]              w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    logic [AXI_ID_WIDTH-1:0] b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [AXI_ID_WIDTH-1:0] ar_id;
    logic [31:0]             ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [31:0]             r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/ahb_axi_master_bridge.sv
// AHB-lite slave to AXI4 master bridge: each AHB beat becomes one single-beat AXI transaction,
// with at most one outstanding; AXI SLVERR/DECERR become a two-cycle AHB ERROR response.
module ahb_axi_master_bridge #(
    parameter int AXI_ID_WIDTH = 4,
    parameter int AXI_ID       = 0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_hsel,
    input  logic [31:0] s_haddr,
    input  logic [1:0]  s_htrans,
    input  logic [2:0]  s_hsize,
    input  logic [2:0]  s_hburst,
    input  logic [3:0]  s_hprot,
    input  logic        s_hwrite,
    input  logic [31:0] s_hwdata,
    input  logic        s_hready_in,
    output logic [31:0] s_hrdata,
    output logic        s_hready_out,
    output logic        s_hresp,
    AXI_BUS.Master      mst
);

    typedef enum logic [3:0] {
        S_IDLE, S_WDATA, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t      state;
    logic [31:0] haddr_q;
    logic [2:0]  hsize_q;
    logic [3:0]  hprot_q;
    logic [31:0] wdata_q;
    logic        aw_valid_q;
    logic        w_valid_q;
    logic        ar_valid_q;
    logic        b_ready_q;
    logic        r_ready_q;
    logic [3:0]  strb;

    logic accept;
    logic unused_ok;

    // Burst type and SEQ-vs-NONSEQ carry no information once every beat is a single AXI transfer.
    assign unused_ok = ^{s_hburst, s_htrans[0], mst.b_id, mst.r_id, mst.r_last};

    assign accept = s_hsel & s_htrans[1] & s_hready_in;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

    always_comb begin
        strb = 4'b1111;
        case (hsize_q)
            3'd0:    strb = 4'b0001 << haddr_q[1:0];
            3'd1:    strb = 4'b0011 << {haddr_q[1], 1'b0};
            default: strb = 4'b1111;
        endcase
    end

    // Address/control fields are static for the life of a transaction, so both channels share them.
    assign mst.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign mst.aw_addr   = haddr_q;
    assign mst.aw_len    = 8'd0;
    assign mst.aw_size   = hsize_q;
    assign mst.aw_burst  = 2'b01;
    assign mst.aw_lock   = 1'b0;
    assign mst.aw_cache  = {2'b00, hprot_q[3], hprot_q[2]};
    assign mst.aw_prot   = {~hprot_q[0], 1'b0, hprot_q[1]};
    assign mst.aw_qos    = 4'd0;
    assign mst.aw_region = 4'd0;
    assign mst.aw_valid  = aw_valid_q;

    assign mst.w_data    = wdata_q;
    assign mst.w_strb    = strb;
    assign mst.w_last    = 1'b1;
    assign mst.w_valid   = w_valid_q;
    assign mst.b_ready   = b_ready_q;

    assign mst.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign mst.ar_addr   = haddr_q;
    assign mst.ar_len    = 8'd0;
    assign mst.ar_size   = hsize_q;
    assign mst.ar_burst  = 2'b01;
    assign mst.ar_lock   = 1'b0;
    assign mst.ar_cache  = {2'b00, hprot_q[3], hprot_q[2]};
    assign mst.ar_prot   = {~hprot_q[0], 1'b0, hprot_q[1]};
    assign mst.ar_qos    = 4'd0;
    assign mst.ar_region = 4'd0;
    assign mst.ar_valid  = ar_valid_q;
    assign mst.r_ready   = r_ready_q;

    // NOTE: every register here updates with <= so all branches see the pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= S_IDLE;
            haddr_q      <= '0;
            hsize_q      <= '0;
            hprot_q      <= '0;
            wdata_q      <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            b_ready_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            s_hrdata     <= '0;
            s_hready_out <= 1'b1;
            s_hresp      <= 1'b0;
        end else begin
            case (state)
                // The hready_out=1 states double as address-phase acceptance slots.
                S_IDLE, S_DONE, S_ERR2: begin
                    if (accept) begin
                        haddr_q      <= s_haddr;
                        hsize_q      <= s_hsize;
                        hprot_q      <= s_hprot;
                        s_hready_out <= 1'b0;
                        if (s_hsize > 3'd2) begin
                            state   <= S_ERR1;
                            s_hresp <= 1'b1;
                        end else if (s_hwrite) begin
                            state   <= S_WDATA;
                            s_hresp <= 1'b0;
                        end else begin
                            state      <= S_RADDR;
                            ar_valid_q <= 1'b1;
                            s_hresp    <= 1'b0;
                        end
                    end else begin
                        state        <= S_IDLE;
                        s_hready_out <= 1'b1;
                        s_hresp      <= 1'b0;
                    end
                end
                S_WDATA: begin
                    wdata_q    <= s_hwdata;
                    aw_valid_q <= 1'b1;
                    w_valid_q  <= 1'b1;
                    state      <= S_WADDR;
                end
                S_WADDR: begin
                    if (mst.aw_ready) aw_valid_q <= 1'b0;
                    if (mst.w_ready)  w_valid_q  <= 1'b0;
                    if ((!aw_valid_q || mst.aw_ready) && (!w_valid_q || mst.w_ready)) begin
                        state     <= S_WRESP;
                        b_ready_q <= 1'b1;
                    end
                end
                S_WRESP: begin
                    if (mst.b_valid) begin
                        b_ready_q <= 1'b0;
                        if (resp_is_err(mst.b_resp)) begin
                            state   <= S_ERR1;
                            s_hresp <= 1'b1;
                        end else begin
                            state        <= S_DONE;
                            s_hready_out <= 1'b1;
                            s_hresp      <= 1'b0;
                        end
                    end
                end
                S_RADDR: begin
                    if (mst.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (mst.r_valid) begin
                        r_ready_q <= 1'b0;
                        s_hrdata  <= mst.r_data;
                        if (resp_is_err(mst.r_resp)) begin
                            state   <= S_ERR1;
                            s_hresp <= 1'b1;
                        end else begin
                            state        <= S_DONE;
                            s_hready_out <= 1'b1;
                            s_hresp      <= 1'b0;
                        end
                    end
                end
                S_ERR1: begin
                    state        <= S_ERR2;
                    s_hready_out <= 1'b1;
                    s_hresp      <= 1'b1;
                end
                default: begin
                    state        <= S_IDLE;
                    aw_valid_q   <= 1'b0;
                    w_valid_q    <= 1'b0;
                    ar_valid_q   <= 1'b0;
                    b_ready_q    <= 1'b0;
                    r_ready_q    <= 1'b0;
                    s_hready_out <= 1'b1;
                    s_hresp      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_axi_master_bridge.sv
// Bench for ahb_axi_master_bridge: a delay-programmable AXI slave plus a transfer-level reference
// model predicting the AXI beats, the AHB response and the completion cycle of every transfer.
`timescale 1ns/1ps
module tb_ahb_axi_master_bridge;

    localparam int ID_W   = 4;
    localparam int ID_VAL = 5;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_hsel = 1'b0;
    logic [31:0] s_haddr = '0;
    logic [1:0]  s_htrans = 2'd0;
    logic [2:0]  s_hsize = 3'd0;
    logic [2:0]  s_hburst = 3'd0;
    logic [3:0]  s_hprot = 4'd0;
    logic        s_hwrite = 1'b0;
    logic [31:0] s_hwdata = '0;
    logic        s_hready_in = 1'b1;
    logic [31:0] s_hrdata;
    logic        s_hready_out;
    logic        s_hresp;

    AXI_BUS #(.AXI_ID_WIDTH(ID_W)) axi ();

    ahb_axi_master_bridge #(.AXI_ID_WIDTH(ID_W), .AXI_ID(ID_VAL)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_hsel(s_hsel), .s_haddr(s_haddr),
        .s_htrans(s_htrans), .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot),
        .s_hwrite(s_hwrite), .s_hwdata(s_hwdata), .s_hready_in(s_hready_in),
        .s_hrdata(s_hrdata), .s_hready_out(s_hready_out), .s_hresp(s_hresp), .mst(axi)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0]     addr;
        logic [2:0]      size;
        logic [7:0]      len;
        logic [1:0]      burst;
        logic [2:0]      prot;
        logic [3:0]      cache;
        logic [ID_W-1:0] id;
        logic            lock;
        logic [3:0]      qos;
        logic [3:0]      region;
    } a_rec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_rec_t;

    a_rec_t aw_q[$];
    a_rec_t ar_q[$];
    w_rec_t w_q[$];

    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural AXI slave: each ready/valid rises after its programmed number of cycles.
    initial begin : axi_slave
        int aw_c, w_c, ar_c, b_c, r_c;
        bit aw_seen, w_seen, b_pend, r_pend, b_drop, r_drop;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0; b_drop = 0; r_drop = 0;
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
        axi.b_valid = 0; axi.b_resp = 0; axi.b_id = '0;
        axi.r_valid = 0; axi.r_resp = 0; axi.r_id = '0; axi.r_data = '0; axi.r_last = 1'b1;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0; b_drop = 0; r_drop = 0;
                axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
                axi.b_valid = 0; axi.r_valid = 0;
            end else begin
                if (b_drop) begin axi.b_valid = 0; b_drop = 0; end
                if (r_drop) begin axi.r_valid = 0; r_drop = 0; end

                if (axi.aw_valid && !axi.aw_ready) begin
                    if (aw_c >= aw_delay) axi.aw_ready = 1; else aw_c++;
                end else begin
                    axi.aw_ready = 0; aw_c = 0;
                end
                if (axi.aw_valid && axi.aw_ready) begin
                    aw_q.push_back({axi.aw_addr, axi.aw_size, axi.aw_len, axi.aw_burst, axi.aw_prot,
                                    axi.aw_cache, axi.aw_id, axi.aw_lock, axi.aw_qos, axi.aw_region});
                    aw_seen = 1;
                end

                if (axi.w_valid && !axi.w_ready) begin
                    if (w_c >= w_delay) axi.w_ready = 1; else w_c++;
                end else begin
                    axi.w_ready = 0; w_c = 0;
                end
                if (axi.w_valid && axi.w_ready) begin
                    w_q.push_back({axi.w_data, axi.w_strb, axi.w_last});
                    w_seen = 1;
                end
                if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_c = 0; end

                if (axi.ar_valid && !axi.ar_ready) begin
                    if (ar_c >= ar_delay) axi.ar_ready = 1; else ar_c++;
                end else begin
                    axi.ar_ready = 0; ar_c = 0;
                end
                if (axi.ar_valid && axi.ar_ready) begin
                    ar_q.push_back({axi.ar_addr, axi.ar_size, axi.ar_len, axi.ar_burst, axi.ar_prot,
                                    axi.ar_cache, axi.ar_id, axi.ar_lock, axi.ar_qos, axi.ar_region});
                    r_pend = 1; r_c = 0;
                end

                if (b_pend && !axi.b_valid) begin
                    if (b_c >= b_delay) begin axi.b_valid = 1; axi.b_resp = bresp_cfg; end
                    else b_c++;
                end
                if (axi.b_valid && axi.b_ready) begin b_drop = 1; b_pend = 0; end

                if (r_pend && !axi.r_valid) begin
                    if (r_c >= r_delay) begin
                        axi.r_valid = 1; axi.r_resp = rresp_cfg; axi.r_data = rdata_cfg;
                    end else r_c++;
                end
                if (axi.r_valid && axi.r_ready) begin r_drop = 1; r_pend = 0; end
            end
        end
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_err(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

    // Byte lanes touched by an AHB beat: the naturally aligned group of 2**size bytes holding addr.
    function automatic logic [3:0] lanes(input logic [31:0] addr, input logic [2:0] size);
        int nbytes, base;
        logic [3:0] s;
        nbytes = 1 << size;
        base = int'(addr[1:0]) / nbytes * nbytes;
        s = '0;
        for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + nbytes);
        return s;
    endfunction

    task automatic ahb_wait(input int start, output int lat, output logic prev_resp,
                            output logic resp, output logic [31:0] rdata);
        int n;
        n = start;
        prev_resp = 1'b0;
        while (!s_hready_out && n < 200) begin
            prev_resp = s_hresp;
            @(negedge aclk);
            n++;
        end
        lat = n;
        resp = s_hresp;
        rdata = s_hrdata;
    endtask

    // Called at a negedge; returns in the completing hready_out=1 cycle so the next call is back-to-back.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [2:0] size,
                            input logic write, input logic [3:0] prot, input logic [1:0] trans,
                            input logic [31:0] wdata);
        int exp_lat, lat;
        logic exp_err, prev, resp;
        logic [31:0] rd;
        a_rec_t ea;
        w_rec_t ew;
        bit issued;
        issued = (size <= 3'd2);
        if (!issued) begin
            exp_err = 1'b1;
            exp_lat = 2;
        end else if (write) begin
            exp_err = is_err(bresp_cfg);
            exp_lat = 4 + imax(aw_delay, w_delay) + imax(0, b_delay - 1) + (exp_err ? 1 : 0);
        end else begin
            exp_err = is_err(rresp_cfg);
            exp_lat = 3 + ar_delay + imax(0, r_delay - 1) + (exp_err ? 1 : 0);
        end
        ea.addr = addr; ea.size = size; ea.len = 8'd0; ea.burst = 2'b01;
        ea.prot = {~prot[0], 1'b0, prot[1]}; ea.cache = {2'b00, prot[3], prot[2]};
        ea.id = ID_W'(ID_VAL); ea.lock = 1'b0; ea.qos = 4'd0; ea.region = 4'd0;
        ew.data = wdata; ew.strb = lanes(addr, size); ew.last = 1'b1;

        s_hsel = 1; s_haddr = addr; s_htrans = trans; s_hsize = size; s_hwrite = write;
        s_hprot = prot; s_hburst = 3'($urandom_range(0, 7));
        @(negedge aclk);
        s_hsel = 0; s_htrans = 2'd0; s_hwdata = wdata;
        ahb_wait(1, lat, prev, resp, rd);

        check({tag, "_latency"}, 96'(lat), 96'(exp_lat));
        check({tag, "_hresp"}, 96'(resp), 96'(exp_err));
        check({tag, "_err1_hresp"}, 96'(prev), 96'(exp_err));
        check({tag, "_aw_count"}, 96'(aw_q.size()), 96'((issued && write) ? 1 : 0));
        check({tag, "_w_count"}, 96'(w_q.size()), 96'((issued && write) ? 1 : 0));
        check({tag, "_ar_count"}, 96'(ar_q.size()), 96'((issued && !write) ? 1 : 0));
        if (issued && write && aw_q.size() == 1 && w_q.size() == 1) begin
            check({tag, "_aw_fields"}, 96'(aw_q[0]), 96'(ea));
            check({tag, "_w_beat"}, 96'(w_q[0]), 96'(ew));
        end
        if (issued && !write && ar_q.size() == 1) begin
            check({tag, "_ar_fields"}, 96'(ar_q[0]), 96'(ea));
            check({tag, "_hrdata"}, 96'(rd), 96'(rdata_cfg));
        end
        aw_q.delete(); w_q.delete(); ar_q.delete();
    endtask

    task automatic set_delays(input int aw, input int w, input int ar, input int b, input int r);
        aw_delay = aw; w_delay = w; ar_delay = ar; b_delay = b; r_delay = r;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        logic prev, resp;
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0] sz;

        repeat (3) @(negedge aclk);
        check("rst_hready_out", 96'(s_hready_out), 96'(1));
        check("rst_hresp", 96'(s_hresp), 96'(0));
        check("rst_hrdata", 96'(s_hrdata), 96'(0));
        check("rst_axi_hs", 96'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}),
              96'(0));
        aresetn = 1;
        @(negedge aclk);

        // IDLE / BUSY transfers and deselected NONSEQ: zero-wait OKAY, nothing on AXI.
        s_hsel = 1; s_htrans = 2'd0; s_hwrite = 1;
        @(negedge aclk);
        check("idle_hready", 96'({s_hready_out, s_hresp}), 96'(2'b10));
        s_htrans = 2'd1;
        @(negedge aclk);
        check("busy_hready", 96'({s_hready_out, s_hresp}), 96'(2'b10));
        s_hsel = 0; s_htrans = 2'd2;
        @(negedge aclk);
        check("nosel_hready", 96'({s_hready_out, s_hresp}), 96'(2'b10));
        s_htrans = 2'd0;
        @(negedge aclk);
        check("idle_no_axi", 96'(aw_q.size() + w_q.size() + ar_q.size()), 96'(0));

        // Directed scenarios against a zero-wait slave.
        set_delays(0, 0, 0, 0, 0);
        run_xfer("word_wr", 32'h1000_0004, 3'd2, 1'b1, 4'b0011, 2'd2, 32'hDEAD_BEEF);
        run_xfer("byte_wr", 32'h2000_0003, 3'd0, 1'b1, 4'b1101, 2'd2, 32'hAB00_0000);
        run_xfer("half_wr", 32'h2000_0002, 3'd1, 1'b1, 4'b0110, 2'd2, 32'h5A5A_0000);
        run_xfer("size3_wr", 32'h2000_0000, 3'd3, 1'b1, 4'b0000, 2'd2, 32'h0);

        set_delays(0, 0, 0, 0, 5);
        rdata_cfg = 32'h1234_5678;
        run_xfer("slow_rd", 32'h3000_0010, 3'd2, 1'b0, 4'b1010, 2'd2, 32'h0);

        // SLVERR write followed by a read presented in the ERR2 cycle.
        set_delays(0, 0, 0, 0, 0);
        bresp_cfg = 2'b10;
        run_xfer("slverr_wr", 32'h4000_0000, 3'd2, 1'b1, 4'b0001, 2'd2, 32'h0BAD_0BAD);
        bresp_cfg = 2'b00;
        rdata_cfg = 32'h0F0F_1234;
        run_xfer("after_err_rd", 32'h4000_0008, 3'd2, 1'b0, 4'b0001, 2'd2, 32'h0);
        @(negedge aclk);

        // AW stalls three cycles while W is accepted at once.
        set_delays(3, 0, 0, 0, 0);
        s_hsel = 1; s_haddr = 32'h5000_0000; s_htrans = 2'd2; s_hsize = 3'd2; s_hwrite = 1;
        s_hprot = 4'b0011;
        @(negedge aclk);
        s_hsel = 0; s_htrans = 2'd0; s_hwdata = 32'hC0DE_C0DE;
        @(negedge aclk);
        check("stall_c2_valids", 96'({axi.aw_valid, axi.w_valid}), 96'(2'b11));
        @(negedge aclk);
        check("stall_c3_valids", 96'({axi.aw_valid, axi.w_valid}), 96'(2'b10));
        ahb_wait(3, lat, prev, resp, rd);
        check("stall_latency", 96'(lat), 96'(7));
        check("stall_hresp", 96'(resp), 96'(0));
        check("stall_one_aw_one_w", 96'({aw_q.size(), w_q.size()}), 96'({32'd1, 32'd1}));
        aw_q.delete(); w_q.delete(); ar_q.delete();
        @(negedge aclk);

        // INCR4 read split into four single-beat AXI reads.
        set_delays(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rdata_cfg = 32'hCAFE_0000 + 32'(i);
            run_xfer($sformatf("incr4_b%0d", i), 32'h6000_0100 + 32'(4 * i), 3'd2, 1'b0, 4'b0011,
                     (i == 0) ? 2'd2 : 2'd3, 32'h0);
        end

        // Randomised transfers, back-to-back, with random slave timing and responses.
        for (int n = 0; n < 24; n++) begin
            set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            rdata_cfg = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a = $urandom;
            if (sz <= 3'd2) a = a & ~(32'(1 << sz) - 32'd1);
            run_xfer($sformatf("rnd%0d", n), a, sz, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     2'($urandom_range(2, 3)), $urandom);
        end
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b00;
        @(negedge aclk);

        // Asynchronous reset while waiting in RDATA.
        set_delays(0, 0, 0, 0, 20);
        rdata_cfg = 32'h7777_7777;
        s_hsel = 1; s_haddr = 32'h7000_0000; s_htrans = 2'd2; s_hsize = 3'd2; s_hwrite = 0;
        @(negedge aclk);
        s_hsel = 0; s_htrans = 2'd0;
        @(negedge aclk);
        check("pre_rst_in_rdata", 96'({s_hready_out, axi.r_ready}), 96'(2'b01));
        aresetn = 0;
        #1;
        check("mid_rst_hready_out", 96'(s_hready_out), 96'(1));
        check("mid_rst_hresp", 96'(s_hresp), 96'(0));
        check("mid_rst_hrdata", 96'(s_hrdata), 96'(0));
        check("mid_rst_axi_hs", 96'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}),
              96'(0));
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1;
        aw_q.delete(); w_q.delete(); ar_q.delete();
        @(negedge aclk);
        set_delays(0, 0, 0, 0, 0);
        run_xfer("post_rst_wr", 32'h7000_0006, 3'd1, 1'b1, 4'b1000, 2'd2, 32'h1234_0000);

        @(negedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
